// File: rtl/lcb_rx_collector.sv
// N-channel LCB reply collector: per-channel byte capture, round-robin drain of
// complete replies, and packing into orbit RAM words on the bank not being read.
module lcb_rx_collector #(
  parameter int NCH    = 5,
  parameter int BYTES  = 4,
  parameter int BYTE_W = 8,
  parameter int WORD_W = 12,
  parameter int ADDR_W = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        iValid,
  input  logic [NCH*BYTE_W-1:0] iData,
  input  logic [NCH-1:0]        iRstCh,
  input  logic [NCH*ADDR_W-1:0] iBase,
  input  logic                  iSW,
  input  logic                  iOvfClr,
  output logic                  oWE,
  output logic                  oWrBank,
  output logic [ADDR_W-1:0]     oWrAddr,
  output logic [WORD_W-1:0]     oWord,
  output logic [NCH-1:0]        oDone,
  output logic [NCH-1:0]        oOvf,
  output logic                  oBusy
);

  localparam int CNT_W = $clog2(BYTES + 1);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, EMIT} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              bank_q, bank_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic [CNT_W-1:0]  cnt_q [NCH];
  logic [NCH-1:0]    rdy_q;
  logic [NCH-1:0]    ovf_q;
  logic [BYTE_W-1:0] byteBuf_q [NCH][BYTES];

  logic              we_q, we_d;
  logic              wrBank_q, wrBank_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [NCH-1:0]    done_q, done_d;

  logic              lastEmit;
  logic [NCH-1:0]    drainClr;
  logic              pickValid;
  logic [CH_W-1:0]   pick;
  logic [CH_W-1:0]   scan;

  assign lastEmit = (state_q == EMIT) && (idx_q == IDX_W'(BYTES - 1));
  assign drainClr = lastEmit ? (NCH'(1) << ch_q) : '0;

  // A ready channel is frozen until drained; extra strobes only raise overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q <= '0;
      ovf_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c] <= '0;
        for (int b = 0; b < BYTES; b++) byteBuf_q[c][b] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        ovf_q[c] <= (ovf_q[c] & ~iOvfClr) | (iValid[c] & rdy_q[c]);
        if (drainClr[c]) begin
          cnt_q[c] <= '0;
          rdy_q[c] <= 1'b0;
        end else if (!rdy_q[c]) begin
          if (iRstCh[c]) begin
            cnt_q[c] <= '0;
          end else if (iValid[c]) begin
            byteBuf_q[c][IDX_W'(cnt_q[c])] <= iData[c*BYTE_W +: BYTE_W];
            cnt_q[c] <= cnt_q[c] + CNT_W'(1);
            if (cnt_q[c] == CNT_W'(BYTES - 1)) rdy_q[c] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    pickValid = 1'b0;
    pick      = '0;
    scan      = '0;
    for (int i = 0; i < NCH; i++) begin
      scan = CH_W'((int'(ptr_q) + i) % NCH);
      if (!pickValid && rdy_q[scan]) begin
        pickValid = 1'b1;
        pick      = scan;
      end
    end
  end

  // Bank and base are latched at grant so a reply never straddles a bank swap.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    ptr_d    = ptr_q;
    base_d   = base_q;
    bank_d   = bank_q;
    idx_d    = idx_q;
    we_d     = 1'b0;
    wrBank_d = 1'b0;
    wrAddr_d = '0;
    word_d   = '0;
    done_d   = '0;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          ch_d    = pick;
          base_d  = iBase[pick*ADDR_W +: ADDR_W];
          bank_d  = ~iSW;
          ptr_d   = (pick == CH_W'(NCH - 1)) ? '0 : pick + CH_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        idx_d   = '0;
        state_d = EMIT;
      end
      EMIT: begin
        we_d     = 1'b1;
        wrBank_d = bank_q;
        wrAddr_d = base_q + ADDR_W'(idx_q);
        word_d   = WORD_W'(byteBuf_q[ch_q][idx_q]) << (WORD_W - BYTE_W);
        if (lastEmit) begin
          done_d  = drainClr;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      ptr_q    <= '0;
      base_q   <= '0;
      bank_q   <= 1'b0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      wrBank_q <= 1'b0;
      wrAddr_q <= '0;
      word_q   <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      ptr_q    <= ptr_d;
      base_q   <= base_d;
      bank_q   <= bank_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      wrBank_q <= wrBank_d;
      wrAddr_q <= wrAddr_d;
      word_q   <= word_d;
      done_q   <= done_d;
    end
  end

  assign oWE     = we_q;
  assign oWrBank = wrBank_q;
  assign oWrAddr = wrAddr_q;
  assign oWord   = word_q;
  assign oDone   = done_q;
  assign oOvf    = ovf_q;
  assign oBusy   = (state_q != IDLE);

endmodule

// File: tb/tb_lcb_rx_collector.sv
// Bench for lcb_rx_collector: directed scenarios with random bytes, bases and banks,
// checked against a reply-level model (per-channel byte queues, round-robin pointer).
module tb_lcb_rx_collector;

  localparam int NCH    = 5;
  localparam int BYTES  = 4;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 12;
  localparam int ADDR_W = 11;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NCH-1:0]        iValid = '0;
  logic [NCH*BYTE_W-1:0] iData = '0;
  logic [NCH-1:0]        iRstCh = '0;
  logic [NCH*ADDR_W-1:0] iBase = '0;
  logic                  iSW = 1'b0;
  logic                  iOvfClr = 1'b0;
  logic                  oWE;
  logic                  oWrBank;
  logic [ADDR_W-1:0]     oWrAddr;
  logic [WORD_W-1:0]     oWord;
  logic [NCH-1:0]        oDone;
  logic [NCH-1:0]        oOvf;
  logic                  oBusy;

  lcb_rx_collector #(.NCH(NCH), .BYTES(BYTES), .BYTE_W(BYTE_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .iValid(iValid), .iData(iData), .iRstCh(iRstCh), .iBase(iBase),
    .iSW(iSW), .iOvfClr(iOvfClr), .oWE(oWE), .oWrBank(oWrBank), .oWrAddr(oWrAddr),
    .oWord(oWord), .oDone(oDone), .oOvf(oOvf), .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic              bank;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] word;
    logic [NCH-1:0]    done;
  } wr_t;

  wr_t wrLog[$];
  int  strayDone = 0;

  always @(negedge clk) begin
    if (oWE === 1'b1) wrLog.push_back('{cyc, oWrBank, oWrAddr, oWord, oDone});
    else if (oDone !== '0) strayDone++;
  end

  // Reference model: accepted bytes per channel, sticky overflow, next round-robin start.
  logic [BYTE_W-1:0] mReply [NCH][$];
  logic [NCH-1:0]    mOvf = '0;
  int                mNext = 0;
  int                mBase [NCH];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NCH*BYTE_W-1:0] byteOn(input int ch, input logic [BYTE_W-1:0] b);
    byteOn = '0;
    byteOn[ch*BYTE_W +: BYTE_W] = b;
  endfunction

  task automatic setBase(input int ch, input int b);
    iBase[ch*ADDR_W +: ADDR_W] = ADDR_W'(b);
    mBase[ch] = b;
  endtask

  task automatic modelStep(input logic [NCH-1:0] valid, input logic [NCH*BYTE_W-1:0] data,
                           input logic [NCH-1:0] rstCh, input logic clr);
    logic [NCH-1:0] newOvf;
    newOvf = '0;
    for (int c = 0; c < NCH; c++) begin
      if (rstCh[c] && mReply[c].size() < BYTES) mReply[c].delete();
      else if (valid[c]) begin
        if (mReply[c].size() == BYTES) newOvf[c] = 1'b1;
        else mReply[c].push_back(data[c*BYTE_W +: BYTE_W]);
      end
    end
    mOvf = (mOvf & ~{NCH{clr}}) | newOvf;
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] valid, input logic [NCH*BYTE_W-1:0] data,
                               input logic [NCH-1:0] rstCh, input logic clr);
    iValid  = valid;
    iData   = data;
    iRstCh  = rstCh;
    iOvfClr = clr;
    modelStep(valid, data, rstCh, clr);
    tick();
    iValid  = '0;
    iData   = '0;
    iRstCh  = '0;
    iOvfClr = 1'b0;
  endtask

  task automatic sendReply(input int ch);
    for (int i = 0; i < BYTES; i++)
      applyStimulus(NCH'(1) << ch, byteOn(ch, BYTE_W'($urandom)), '0, 1'b0);
  endtask

  task automatic sendParallel(input logic [NCH-1:0] mask);
    logic [NCH*BYTE_W-1:0] d;
    for (int i = 0; i < BYTES; i++) begin
      d = '0;
      for (int c = 0; c < NCH; c++)
        if (mask[c]) d[c*BYTE_W +: BYTE_W] = BYTE_W'($urandom);
      applyStimulus(mask, d, '0, 1'b0);
    end
  endtask

  // Pops one reply's writes from the log and compares them with the model's next grant.
  task automatic checkDrain(input logic expBank, output int first, output int last);
    int  ch;
    int  n;
    wr_t r;
    first = 0;
    last  = 0;
    ch    = -1;
    for (int i = 0; i < NCH; i++) begin
      int c;
      c = (mNext + i) % NCH;
      if (ch < 0 && mReply[c].size() == BYTES) ch = c;
    end
    if (ch < 0) begin
      errors++;
      $display("[TB] FAIL modelPick: no ready reply in model");
      return;
    end
    n = 0;
    while (wrLog.size() < BYTES && n < 60) begin
      tick();
      n++;
    end
    checkOutput($sformatf("writesArrived ch%0d", ch), wrLog.size() >= BYTES, 1);
    if (wrLog.size() < BYTES) return;
    for (int i = 0; i < BYTES; i++) begin
      r = wrLog.pop_front();
      if (i == 0) first = r.cyc;
      checkOutput($sformatf("addr ch%0d w%0d", ch, i), r.addr, (mBase[ch] + i) % (1 << ADDR_W));
      checkOutput($sformatf("word ch%0d w%0d", ch, i), r.word, int'(mReply[ch][i]) << (WORD_W - BYTE_W));
      checkOutput($sformatf("bank ch%0d w%0d", ch, i), r.bank, expBank);
      checkOutput($sformatf("done ch%0d w%0d", ch, i), r.done, (i == BYTES - 1) ? (1 << ch) : 0);
      checkOutput($sformatf("contig ch%0d w%0d", ch, i), r.cyc, first + i);
      last = r.cyc;
    end
    mReply[ch].delete();
    mNext = (ch + 1) % NCH;
  endtask

  initial begin
    int   f1, l1, f2, l2, f3, l3;
    int   lastEdge;
    int   ch;
    logic sw;

    $display("[TB] reset state");
    repeat (3) tick();
    checkOutput("rst oWE", oWE, 0);
    checkOutput("rst oBusy", oBusy, 0);
    checkOutput("rst oDone", oDone, 0);
    checkOutput("rst oOvf", oOvf, 0);
    checkOutput("rst oWrAddr", oWrAddr, 0);
    checkOutput("rst oWord", oWord, 0);
    checkOutput("rst oWrBank", oWrBank, 0);
    rst = 1'b0;
    tick();

    $display("[TB] single reply on ch2");
    setBase(2, 100);
    iSW = 1'b0;
    for (int i = 0; i < BYTES; i++)
      applyStimulus(NCH'(1) << 2, byteOn(2, BYTE_W'(8'h11 * (i + 1))), '0, 1'b0);
    lastEdge = cyc;
    checkDrain(1'b1, f1, l1);
    checkOutput("latency ch2", f1, lastEdge + 3);

    $display("[TB] random single replies");
    for (int k = 0; k < 4; k++) begin
      ch = $urandom_range(NCH - 1);
      sw = 1'($urandom_range(1));
      iSW = sw;
      setBase(ch, $urandom_range((1 << ADDR_W) - 1));
      sendReply(ch);
      lastEdge = cyc;
      checkDrain(~sw, f1, l1);
      checkOutput("latency random", f1, lastEdge + 3);
    end

    $display("[TB] round-robin fairness");
    iSW = 1'b0;
    setBase(3, $urandom_range((1 << ADDR_W) - 1));
    sendReply(3);
    checkDrain(1'b1, f1, l1);
    setBase(0, $urandom_range((1 << ADDR_W) - 1));
    setBase(4, $urandom_range((1 << ADDR_W) - 1));
    sendParallel(5'b11001);
    checkDrain(1'b1, f1, l1);
    checkDrain(1'b1, f2, l2);
    checkDrain(1'b1, f3, l3);
    checkOutput("gap first->second", f2 - l1, 3);
    checkOutput("gap second->third", f3 - l2, 3);

    $display("[TB] overflow");
    setBase(1, $urandom_range((1 << ADDR_W) - 1));
    sendParallel(5'b00011);
    applyStimulus(NCH'(1) << 1, byteOn(1, BYTE_W'($urandom)), '0, 1'b0);
    checkOutput("ovf set", oOvf, mOvf);
    applyStimulus(NCH'(1) << 1, byteOn(1, BYTE_W'($urandom)), '0, 1'b1);
    checkOutput("ovf clr collides with overflow", oOvf, mOvf);
    checkDrain(1'b1, f1, l1);
    checkDrain(1'b1, f2, l2);
    checkOutput("ovf sticky", oOvf, mOvf);
    applyStimulus('0, '0, '0, 1'b1);
    checkOutput("ovf cleared", oOvf, mOvf);

    $display("[TB] partial discard and address wrap");
    setBase(0, 2046);
    applyStimulus(5'b00001, byteOn(0, BYTE_W'($urandom)), '0, 1'b0);
    applyStimulus(5'b00001, byteOn(0, BYTE_W'($urandom)), '0, 1'b0);
    applyStimulus(5'b00001, byteOn(0, BYTE_W'($urandom)), 5'b00001, 1'b0);
    sendReply(0);
    checkDrain(1'b1, f1, l1);

    $display("[TB] bank hold");
    iSW = 1'b0;
    ch = $urandom_range(NCH - 1);
    setBase(ch, $urandom_range((1 << ADDR_W) - 1));
    sendReply(ch);
    repeat (3) tick();
    iSW = 1'b1;
    checkDrain(1'b1, f1, l1);
    ch = $urandom_range(NCH - 1);
    setBase(ch, $urandom_range((1 << ADDR_W) - 1));
    sendReply(ch);
    checkDrain(1'b0, f1, l1);

    $display("[TB] reset mid-drain");
    iSW = 1'b0;
    setBase(3, $urandom_range((1 << ADDR_W) - 1));
    sendReply(3);
    applyStimulus(NCH'(1) << 3, byteOn(3, BYTE_W'($urandom)), '0, 1'b0);
    tick();
    tick();
    checkOutput("pre-reset oWE", oWE, 1);
    checkOutput("pre-reset oOvf", oOvf, mOvf);
    rst = 1'b1;
    #1;
    checkOutput("mid-drain rst oWE", oWE, 0);
    checkOutput("mid-drain rst oBusy", oBusy, 0);
    checkOutput("mid-drain rst oDone", oDone, 0);
    checkOutput("mid-drain rst oOvf", oOvf, 0);
    for (int c = 0; c < NCH; c++) mReply[c].delete();
    mOvf  = '0;
    mNext = 0;
    tick();
    tick();
    wrLog.delete();
    rst = 1'b0;
    tick();
    setBase(0, $urandom_range((1 << ADDR_W) - 1));
    setBase(4, $urandom_range((1 << ADDR_W) - 1));
    sendParallel(5'b10001);
    lastEdge = cyc;
    checkDrain(1'b1, f1, l1);
    checkDrain(1'b1, f2, l2);
    checkOutput("latency after reset", f1, lastEdge + 3);
    checkOutput("gap after reset", f2 - l1, 3);

    repeat (6) tick();
    checkOutput("no extra writes", wrLog.size(), 0);
    checkOutput("no stray done", strayDone, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
